// File: rtl/ntt_pkg.sv
// ---------------------------------------------------------------------------
// ntt_pkg
// Shared definitions for the NTT butterfly datapath:
//   bf_mode_e  - butterfly flavour (Cooley-Tukey forward, Gentleman-Sande inverse)
//   BF_LAT     - accept-to-present latency of ntt_butterfly_pipe, in cycles
//   barrett_mu - Barrett constant floor(2^(2K) / q), evaluated at elaboration
//   inv2_mod   - x * 2^-1 mod q for x < q (halving in the odd/even form)
// ---------------------------------------------------------------------------
package ntt_pkg;

  typedef enum logic {
    BF_CT = 1'b0,
    BF_GS = 1'b1
  } bf_mode_e;

  localparam int BF_LAT = 4;

  // 2^(2K) can exceed 64 bits for K = 32, so the division runs in a wide temporary.
  function automatic longint unsigned barrett_mu(input longint unsigned q, input int k);
    logic [129:0] num;
    num = 130'd1 << (2 * k);
    return 64'(num / 130'(q));
  endfunction

  // For odd q, x/2 mod q is x>>1 when x is even and (x+q)>>1 when x is odd.
  function automatic longint unsigned inv2_mod(input longint unsigned x, input longint unsigned q);
    longint unsigned t;
    t = x;
    if (t[0]) t = t + q;
    return t >> 1;
  endfunction

endpackage

// File: rtl/mod_mul_barrett.sv
// ---------------------------------------------------------------------------
// mod_mul_barrett
// Three-register modular multiplier r = x*y mod Q using Barrett reduction.
//   reg 1: full 2W-bit product
//   reg 2: quotient estimate (product carried alongside)
//   reg 3: remainder after at most two conditional subtractions of Q
// The whole pipeline moves only when en=1; valid tracking lives in the parent.
// Ports:
//   clk - clock
//   en  - pipeline advance
//   x,y - operands, both < Q
//   r   - x*y mod Q, three enabled cycles after x,y are presented
// ---------------------------------------------------------------------------
module mod_mul_barrett
  import ntt_pkg::*;
#(
  parameter int              W = 32,
  parameter longint unsigned Q = 40961
) (
  input  logic         clk,
  input  logic         en,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] r
);

  localparam int              K   = $clog2(Q);
  localparam int              PW  = 2 * W;
  localparam int              EW  = 2 * K + 2;
  localparam logic [K:0]      MU  = (K + 1)'(barrett_mu(Q, K));
  localparam logic [PW-1:0]   Q_P = PW'(Q);
  localparam logic [W+1:0]    Q_R = (W + 2)'(Q);

  logic [PW-1:0] prod_s1;
  logic [PW-1:0] prod_s2;
  logic [K:0]    q_est_s2;

  logic [K:0]    prod_hi;
  logic [EW-1:0] q_prod;
  logic [K:0]    q_est;
  logic [W+1:0]  r_raw;
  logic [W+1:0]  r_fix1;
  logic [W+1:0]  r_fix2;

  // prod < Q^2 < 2^(2K), so prod>>(K-1) fits in K+1 bits, and MU < 2^(K+1).
  always_comb begin
    prod_hi = (K + 1)'(prod_s1 >> (K - 1));
    q_prod  = EW'(prod_hi) * EW'(MU);
    q_est   = (K + 1)'(q_prod >> (K + 1));
  end

  // The estimate undershoots the true quotient by at most 2, so r_raw < 3Q.
  always_comb begin
    r_raw  = (W + 2)'(prod_s2 - PW'(q_est_s2) * Q_P);
    r_fix1 = (r_raw  >= Q_R) ? r_raw  - Q_R : r_raw;
    r_fix2 = (r_fix1 >= Q_R) ? r_fix1 - Q_R : r_fix1;
  end

  // NOTE: non-blocking assignments let every register sample the pre-edge value
  // of its predecessor, which is what makes this a pipeline instead of a chain.
  // NOTE: pure datapath registers carry no reset; their contents only matter
  // when the parent's matching valid bit is set, and that bit is reset.
  always_ff @(posedge clk) begin
    if (en) begin
      prod_s1  <= PW'(x) * PW'(y);
      prod_s2  <= prod_s1;
      q_est_s2 <= q_est;
      r        <= W'(r_fix2);
    end
  end

endmodule

// File: rtl/ntt_butterfly_pipe.sv
// ---------------------------------------------------------------------------
// ntt_butterfly_pipe
// Multi-lane radix-2 NTT butterfly with valid/ready flow control.
//   CT (mode 0): P = B*W;  A' = A+P;  B' = A-P            (all mod Q)
//   GS (mode 1): A' = A+B; B' = (A-B)*W; optional halving of both (all mod Q)
// Register chain (one whole-pipeline advance per step):
//   s0  : captured inputs; GS add/sub and multiplier operand select follow it
//   s1-3: the three registers of mod_mul_barrett, sideband carried in step
//   out : CT add/sub and GS halving, presented to the consumer
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   in_valid/in_ready   - input handshake (in_ready does not depend on in_valid)
//   in_mode, in_halve   - butterfly flavour, GS halving request
//   in_a, in_b, in_w    - per-lane operands, lane i at [i*W +: W]
//   in_tag              - opaque tag returned with the result
//   out_valid/out_ready - output handshake
//   out_a, out_b        - per-lane results
//   out_tag             - tag of the presented transaction
// ---------------------------------------------------------------------------
module ntt_butterfly_pipe
  import ntt_pkg::*;
#(
  parameter int              W     = 32,
  parameter longint unsigned Q     = 40961,
  parameter int              LANES = 1,
  parameter int              TAG_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic                 in_halve,
  input  logic [LANES*W-1:0]   in_a,
  input  logic [LANES*W-1:0]   in_b,
  input  logic [LANES*W-1:0]   in_w,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   out_a,
  output logic [LANES*W-1:0]   out_b,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int         LW  = LANES * W;
  localparam logic [W:0] Q_X = (W + 1)'(Q);

  typedef struct packed {
    logic             valid;
    bf_mode_e         mode;
    logic             halve;
    logic [TAG_W-1:0] tag;
  } side_t;

  function automatic logic [W-1:0] add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= Q_X) s = s - Q_X;
    return W'(s);
  endfunction

  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    if (x >= y) s = {1'b0, x} - {1'b0, y};
    else        s = {1'b0, x} + Q_X - {1'b0, y};
    return W'(s);
  endfunction

  function automatic logic [W-1:0] halve_mod(input logic [W-1:0] x);
    logic [W:0] s;
    s = {1'b0, x} + (x[0] ? Q_X : '0);
    return W'(s >> 1);
  endfunction

  logic    advance;
  side_t   s0_side, s1_side, s2_side, s3_side;
  logic [LW-1:0] s0_a, s0_b, s0_w;
  // A in CT mode, (A+B) mod Q in GS mode; travels beside the multiplier.
  logic [LW-1:0] keep_s0, s1_keep, s2_keep, s3_keep;
  logic [LW-1:0] mul_x, mul_r, res_a, res_b;

  // Everything moves together; a full output register that is not being
  // drained freezes the whole chain, bubbles included.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_side   <= '0;
      s1_side   <= '0;
      s2_side   <= '0;
      s3_side   <= '0;
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_tag   <= '0;
    end else if (advance) begin
      s0_side   <= '{valid: in_valid, mode: bf_mode_e'(in_mode), halve: in_halve, tag: in_tag};
      s1_side   <= s0_side;
      s2_side   <= s1_side;
      s3_side   <= s2_side;
      out_valid <= s3_side.valid;
      out_a     <= res_a;
      out_b     <= res_b;
      out_tag   <= s3_side.tag;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s0_a    <= in_a;
      s0_b    <= in_b;
      s0_w    <= in_w;
      s1_keep <= keep_s0;
      s2_keep <= s1_keep;
      s3_keep <= s2_keep;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [W-1:0] a0, b0;
    logic [W-1:0] keep3, prod3;
    logic [W-1:0] ra, rb;

    assign a0 = s0_a[i*W +: W];
    assign b0 = s0_b[i*W +: W];

    assign keep_s0[i*W +: W] = (s0_side.mode == BF_GS) ? add_mod(a0, b0) : a0;
    assign mul_x[i*W +: W]   = (s0_side.mode == BF_GS) ? sub_mod(a0, b0) : b0;

    mod_mul_barrett #(
      .W (W),
      .Q (Q)
    ) u_mul (
      .clk (clk),
      .en  (advance),
      .x   (mul_x[i*W +: W]),
      .y   (s0_w[i*W +: W]),
      .r   (mul_r[i*W +: W])
    );

    assign keep3 = s3_keep[i*W +: W];
    assign prod3 = mul_r[i*W +: W];

    // NOTE: both results get a value before any branch, so no path through
    // this block leaves them unassigned and no latch can be inferred.
    always_comb begin
      ra = add_mod(keep3, prod3);
      rb = sub_mod(keep3, prod3);
      if (s3_side.mode == BF_GS) begin
        ra = keep3;
        rb = prod3;
        if (s3_side.halve) begin
          ra = halve_mod(ra);
          rb = halve_mod(rb);
        end
      end
    end

    assign res_a[i*W +: W] = ra;
    assign res_b[i*W +: W] = rb;
  end

endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
// ---------------------------------------------------------------------------
// tb_ntt_butterfly_pipe
// Directed corner cases, a backpressure burst, a mid-stream reset and a long
// randomized run on a 4-lane instance. Expected results come from plain
// modular arithmetic on integers, queued in acceptance order.
// ---------------------------------------------------------------------------
module tb_ntt_butterfly_pipe;
  import ntt_pkg::*;

  localparam int              W     = 32;
  localparam longint unsigned Q     = 40961;
  localparam int              LANES = 4;
  localparam int              TAG_W = 8;
  localparam int              LW    = LANES * W;

  typedef logic [LW-1:0] vec_t;
  typedef struct {
    logic [TAG_W-1:0] tag;
    vec_t             a;
    vec_t             b;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready, in_mode, in_halve;
  vec_t             in_a, in_b, in_w;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready;
  vec_t             out_a, out_b;
  logic [TAG_W-1:0] out_tag;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;

  always #5 clk = ~clk;

  ntt_butterfly_pipe #(
    .W     (W),
    .Q     (Q),
    .LANES (LANES),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_halve  (in_halve),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_w      (in_w),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_tag   (out_tag)
  );

  task automatic check(input string name, input vec_t got, input vec_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference butterfly on integers; halving is multiplication by 2^-1 mod Q.
  function automatic void ref_bf(input bit mode, input bit halve,
                                 input longint unsigned a, input longint unsigned b,
                                 input longint unsigned w,
                                 output longint unsigned ra, output longint unsigned rb);
    longint unsigned p, inv2;
    inv2 = inv2_mod(1, Q);
    if (!mode) begin
      p  = (b * w) % Q;
      ra = (a + p) % Q;
      rb = (a + Q - p) % Q;
    end else begin
      ra = (a + b) % Q;
      rb = (((a + Q - b) % Q) * w) % Q;
      if (halve) begin
        ra = (ra * inv2) % Q;
        rb = (rb * inv2) % Q;
      end
    end
  endfunction

  function automatic exp_t expect_txn(input bit mode, input bit halve, input vec_t a,
                                      input vec_t b, input vec_t w, input logic [TAG_W-1:0] tag);
    exp_t e;
    longint unsigned ra, rb;
    e.tag = tag;
    e.a   = '0;
    e.b   = '0;
    for (int i = 0; i < LANES; i++) begin
      ref_bf(mode, halve, 64'(a[i*W +: W]), 64'(b[i*W +: W]), 64'(w[i*W +: W]), ra, rb);
      e.a[i*W +: W] = W'(ra);
      e.b[i*W +: W] = W'(rb);
    end
    return e;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < LANES; i++) v[i*W +: W] = W'($urandom_range(32'(Q - 1)));
    return v;
  endfunction

  function automatic vec_t rep(input longint unsigned x);
    vec_t v;
    for (int i = 0; i < LANES; i++) v[i*W +: W] = W'(x);
    return v;
  endfunction

  // Operands outside [0, Q) are a stimulus error, not a DUT error.
  always @(posedge clk) begin
    if (!reset && in_valid && in_ready) begin
      for (int i = 0; i < LANES; i++) begin
        assert (64'(in_a[i*W +: W]) < Q && 64'(in_b[i*W +: W]) < Q && 64'(in_w[i*W +: W]) < Q)
          else $error("operand out of range on lane %0d", i);
      end
    end
  end

  // Scoreboard: every presented transaction must match the oldest expected one.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", LW'(out_valid), '0);
      end else begin
        check("out_tag", LW'(out_tag), LW'(sb[0].tag));
        check("out_a", out_a, sb[0].a);
        check("out_b", out_b, sb[0].b);
        if (out_ready) begin
          void'(sb.pop_front());
          n_out++;
        end
      end
      if (!out_ready) check("in_ready_stall", LW'(in_ready), '0);
    end
  end

  // Single transaction on an idle pipeline, checked against fixed values.
  task automatic directed(input string name, input bit mode, input bit halve,
                          input longint unsigned a, input longint unsigned b,
                          input longint unsigned w, input longint unsigned ea,
                          input longint unsigned eb, input logic [TAG_W-1:0] tag);
    int lat;
    in_mode   = mode;
    in_halve  = halve;
    in_a      = rep(a);
    in_b      = rep(b);
    in_w      = rep(w);
    in_tag    = tag;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check({name, "_in_ready"}, LW'(in_ready), LW'(1));
    sb.push_back(expect_txn(mode, halve, in_a, in_b, in_w, tag));
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, LW'(lat), LW'(BF_LAT));
    check({name, "_a"}, out_a, rep(ea));
    check({name, "_b"}, out_b, rep(eb));
    check({name, "_tag"}, LW'(out_tag), LW'(tag));
    @(posedge clk);
    #1;
  endtask

  // Streams n transactions. stall_test: tags 1..n, in_valid held, out_ready
  // dropped for three cycles once outputs are flowing.
  task automatic stream(input int n, input bit stall_test, input int vld_pct, input int rdy_pct);
    int               sent = 0;
    int               cyc  = 0;
    bit               need = 1'b1;
    bit               mode, halve;
    vec_t             a, b, w;
    logic [TAG_W-1:0] tag;
    while (sent < n && cyc < 40 * n + 100) begin
      if (need) begin
        mode  = 1'($urandom_range(1));
        halve = 1'($urandom_range(1));
        a     = rand_vec();
        b     = rand_vec();
        w     = rand_vec();
        tag   = stall_test ? TAG_W'(sent + 1) : TAG_W'($urandom);
        need  = 1'b0;
      end
      in_mode   = mode;
      in_halve  = halve;
      in_a      = a;
      in_b      = b;
      in_w      = w;
      in_tag    = tag;
      in_valid  = stall_test ? 1'b1 : ($urandom_range(99) < vld_pct);
      out_ready = stall_test ? !(cyc >= 5 && cyc < 8) : ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb.push_back(expect_txn(mode, halve, a, b, w, tag));
        sent++;
        need = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_sent", LW'(sent), LW'(n));
  endtask

  task automatic drain();
    int c = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("drain_empty", LW'(sb.size()), '0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int seen;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_halve  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_w      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("reset_out_valid", LW'(out_valid), '0);
    check("reset_out_a", out_a, '0);
    check("reset_out_b", out_b, '0);
    check("reset_out_tag", LW'(out_tag), '0);
    check("reset_in_ready", LW'(in_ready), LW'(1));
    @(posedge clk);
    #1;

    directed("ct_basic",      1'b0, 1'b0, 5,     3,     7,     26,    40945, 8'h11);
    directed("gs_basic",      1'b1, 1'b0, 10,    4,     2,     14,    12,    8'h22);
    directed("gs_halve",      1'b1, 1'b1, 10,    4,     2,     7,     6,     8'h33);
    directed("ct_max",        1'b0, 1'b0, 40960, 40960, 40960, 0,     40959, 8'h44);
    directed("gs_odd_halve",  1'b1, 1'b1, 3,     0,     1,     20482, 20482, 8'h55);
    directed("ct_halve_ign",  1'b0, 1'b1, 5,     3,     7,     26,    40945, 8'h66);

    // Backpressure burst: tags 1..8 with a three-cycle stall.
    base = n_out;
    stream(8, 1'b1, 100, 100);
    drain();
    check("bp_delivered", LW'(n_out - base), LW'(8));

    // Reset with three transactions in flight: none of them may surface.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_mode  = 1'b0;
      in_halve = 1'b0;
      in_a     = rand_vec();
      in_b     = rand_vec();
      in_w     = rand_vec();
      in_tag   = TAG_W'(8'hA0 + k);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", LW'(out_valid), '0);
    check("midrst_in_ready", LW'(in_ready), LW'(1));
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_nothing_emitted", LW'(seen), '0);
    @(posedge clk);
    #1;
    directed("post_reset", 1'b1, 1'b0, 10, 4, 2, 14, 12, 8'h77);

    // Long randomized run with random valid and ready.
    stream(10000, 1'b0, 80, 70);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
